// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO write-side burst engine.
//   afifo_wr_mode_e   : data sequencing mode (INC / CONST / LFSR)
//   afifo_wr_status_e : per-burst completion status
//   afifo_wr_state_e  : burst engine FSM states
//   decode_mode()     : maps the raw 2-bit command mode (3 behaves as INC)
//   burst_status()    : priority encode TIMEOUT > DROPPED > OK
package afifo_pkg;

  typedef enum logic [1:0] {
    WR_INC   = 2'd0,
    WR_CONST = 2'd1,
    WR_LFSR  = 2'd2
  } afifo_wr_mode_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_DROPPED = 2'd1,
    ST_TIMEOUT = 2'd2
  } afifo_wr_status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } afifo_wr_state_e;

  function automatic afifo_wr_mode_e decode_mode(input logic [1:0] raw);
    afifo_wr_mode_e m;
    case (raw)
      2'd1:    m = WR_CONST;
      2'd2:    m = WR_LFSR;
      default: m = WR_INC;
    endcase
    return m;
  endfunction

  function automatic afifo_wr_status_e burst_status(input logic timed_out,
                                                    input logic any_drop);
    afifo_wr_status_e s;
    if (timed_out) begin
      s = ST_TIMEOUT;
    end else if (any_drop) begin
      s = ST_DROPPED;
    end else begin
      s = ST_OK;
    end
    return s;
  endfunction

endpackage

// File: rtl/afifo_wr_data_gen.sv
// Registered write-data sequencer for the burst engine.
//   clk, rst_n : write clock, async active-low reset
//   load       : capture seed and mode (command accept)
//   seed       : first beat data
//   mode       : raw 2-bit mode, decoded at load
//   advance    : step to the next beat value (beat written or dropped)
//   data       : current beat value (registered)
module afifo_wr_data_gen
  import afifo_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TAPS       = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [1:0]            mode,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] data
);

  afifo_wr_mode_e        mode_r;
  logic [DATA_WIDTH-1:0] data_r;
  afifo_wr_mode_e        load_mode_s;

  function automatic logic [DATA_WIDTH-1:0] next_data(input logic [DATA_WIDTH-1:0] d,
                                                      input afifo_wr_mode_e m);
    logic [DATA_WIDTH-1:0] n;
    case (m)
      WR_CONST: n = d;
      WR_LFSR:  n = {d[DATA_WIDTH-2:0], ^(d & TAPS)};
      default:  n = d + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endcase
    return n;
  endfunction

  assign load_mode_s = decode_mode(mode);

  // Seed/mode capture and per-beat advance; an all-zero LFSR seed would lock up,
  // so it is replaced by all-ones at load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {DATA_WIDTH{1'b0}};
      mode_r <= WR_INC;
    end else if (load) begin
      mode_r <= load_mode_s;
      if ((load_mode_s == WR_LFSR) && (seed == {DATA_WIDTH{1'b0}})) begin
        data_r <= {DATA_WIDTH{1'b1}};
      end else begin
        data_r <= seed;
      end
    end else if (advance) begin
      data_r <= next_data(data_r, mode_r);
    end else begin
      data_r <= data_r;
    end
  end

  assign data = data_r;

endmodule

// File: rtl/afifo_wr_burst_engine.sv
// Write-side burst stimulus engine for the async FIFO write port (wclk domain).
//   cmd_*        : burst command (valid/ready handshake, accepted only in IDLE)
//   winc/wdata   : FIFO write strobe (never high while wfull) and registered data
//   wfull        : FIFO full; stalls (with timeout) or drops beats per cmd_drop
//   busy/done    : burst in progress / one-cycle end pulse with done_status
//   wr_count     : beats written, drop_count: beats dropped (saturating, hold
//                  until the next command is accepted)
//   full_evt     : one-cycle pulse on a wfull rising edge while busy
module afifo_wr_burst_engine
  import afifo_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int          GAP_WIDTH  = 4,
  parameter int          TMO_CYCLES = 256,
  parameter logic [31:0] LFSR_TAPS  = 32'h8020_0003
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [1:0]            cmd_mode,
  input  logic [GAP_WIDTH-1:0]  cmd_gap,
  input  logic                  cmd_drop,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wfull,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            done_status,
  output logic [LEN_WIDTH-1:0]  wr_count,
  output logic [LEN_WIDTH-1:0]  drop_count,
  output logic                  full_evt
);

  localparam int                TMO_W    = $clog2(TMO_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  afifo_wr_state_e       state_r, state_s;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic [GAP_WIDTH-1:0]  gap_cfg_r, gap_cnt_r;
  logic                  drop_mode_r;
  logic [TMO_W-1:0]      tmo_r;
  logic [TMO_W-1:0]      tmo_inc_s;
  logic [LEN_WIDTH-1:0]  wr_count_r, drop_count_r;
  logic                  timeout_r;
  logic                  done_r;
  afifo_wr_status_e      done_status_r;
  logic                  wfull_q_r;
  logic                  accept_s, write_s, drop_s, stall_s, consume_s, tmo_expire_s;

  assign accept_s     = cmd_valid && (state_r == IDLE);
  assign write_s      = (state_r == WRITE) && !wfull;
  assign drop_s       = (state_r == WRITE) && wfull && drop_mode_r;
  assign stall_s      = (state_r == WRITE) && wfull && !drop_mode_r;
  assign consume_s    = write_s || drop_s;
  assign tmo_inc_s    = tmo_r + TMO_W'(1);
  // The stall that brings the consecutive-full count to TMO_CYCLES-1 aborts.
  assign tmo_expire_s = stall_s && (tmo_inc_s == TMO_LAST);

  // Next-state logic for the burst FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_s = (cmd_len == {LEN_WIDTH{1'b0}}) ? DONE : WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (consume_s) begin
          if (rem_r == LEN_ONE) begin
            state_s = DONE;
          end else if (gap_cfg_r != {GAP_WIDTH{1'b0}}) begin
            state_s = GAP;
          end else begin
            state_s = WRITE;
          end
        end else if (tmo_expire_s) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_ONE) begin
          state_s = WRITE;
        end else begin
          state_s = GAP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst bookkeeping: remaining beats, gap/timeout counters, saturating stats.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rem_r        <= {LEN_WIDTH{1'b0}};
      gap_cfg_r    <= {GAP_WIDTH{1'b0}};
      gap_cnt_r    <= {GAP_WIDTH{1'b0}};
      drop_mode_r  <= 1'b0;
      tmo_r        <= {TMO_W{1'b0}};
      wr_count_r   <= {LEN_WIDTH{1'b0}};
      drop_count_r <= {LEN_WIDTH{1'b0}};
      timeout_r    <= 1'b0;
    end else if (accept_s) begin
      rem_r        <= cmd_len;
      gap_cfg_r    <= cmd_gap;
      drop_mode_r  <= cmd_drop;
      tmo_r        <= {TMO_W{1'b0}};
      wr_count_r   <= {LEN_WIDTH{1'b0}};
      drop_count_r <= {LEN_WIDTH{1'b0}};
      timeout_r    <= 1'b0;
    end else begin
      if (consume_s) begin
        rem_r     <= rem_r - LEN_ONE;
        tmo_r     <= {TMO_W{1'b0}};
        gap_cnt_r <= gap_cfg_r;
      end
      if (write_s && !(&wr_count_r)) begin
        wr_count_r <= wr_count_r + LEN_ONE;
      end
      if (drop_s && !(&drop_count_r)) begin
        drop_count_r <= drop_count_r + LEN_ONE;
      end
      if (stall_s) begin
        tmo_r <= tmo_inc_s;
      end
      if (tmo_expire_s) begin
        timeout_r <= 1'b1;
      end
      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r - GAP_ONE;
      end
    end
  end

  // Completion pulse/status (registered out of DONE) and wfull history.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      done_r        <= 1'b0;
      done_status_r <= ST_OK;
      wfull_q_r     <= 1'b0;
    end else begin
      done_r    <= (state_r == DONE);
      wfull_q_r <= wfull;
      if (state_r == DONE) begin
        done_status_r <= burst_status(timeout_r, drop_count_r != {LEN_WIDTH{1'b0}});
      end else begin
        done_status_r <= done_status_r;
      end
    end
  end

  afifo_wr_data_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (DATA_WIDTH'(LFSR_TAPS))
  ) u_data_gen (
    .clk     (wclk),
    .rst_n   (wrst_n),
    .load    (accept_s),
    .seed    (cmd_seed),
    .mode    (cmd_mode),
    .advance (consume_s),
    .data    (wdata)
  );

  assign winc        = write_s;
  assign cmd_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign done_status = done_status_r;
  assign wr_count    = wr_count_r;
  assign drop_count  = drop_count_r;
  assign full_evt    = busy && wfull && !wfull_q_r;

endmodule
